// File: rtl/muxn_pkg.sv
// Shared definitions for the muxn_stream multiplexer: mode selectors,
// bus-size limits and the channel-slice helper.
package muxn_pkg;

    localparam int MODE_SEL = 0;  // channel picked by the external sel port
    localparam int MODE_RR  = 1;  // channel picked by round-robin arbitration

    localparam int MAX_N = 16;
    localparam int MAX_W = 64;
    localparam int BUS_W = MAX_N * MAX_W;

    // Returns channel idx of a packed channel bus whose channels are w bits wide.
    // The result is MAX_W bits wide and carries neighbouring-channel bits above w,
    // so the caller truncates to its own width.
    function automatic logic [MAX_W-1:0] channel_slice(
        input logic [BUS_W-1:0] bus,
        input int unsigned      idx,
        input int unsigned      w
    );
        logic [BUS_W-1:0] shifted;
        shifted = bus >> (idx * w);
        return shifted[MAX_W-1:0];
    endfunction

endpackage

// File: rtl/muxn_stream_rr_arbiter.sv
// Round-robin arbiter: combinational priority search starting at ptr, plus the
// ptr register, which moves to one past the granted channel when advance_i is set.
module rr_arbiter #(
    parameter int N  = 4,
    parameter int SW = $clog2(N)
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic [N-1:0]  req_i,
    input  logic          advance_i,
    output logic          grant_valid_o,
    output logic [SW-1:0] grant_idx_o
);

    logic [SW-1:0]  ptr_q, ptr_d;
    logic [2*N-1:0] req_dbl;
    logic [N-1:0]   req_rot;
    logic [SW:0]    idx_sum;

    // Rotate the requests so that bit 0 is the channel at ptr.
    assign req_dbl = {req_i, req_i} >> ptr_q;
    assign req_rot = req_dbl[N-1:0];

    // Lowest rotated request wins; map its offset back to an absolute index mod N.
    always_comb begin
        // NOTE: every output of a combinational block gets a default first,
        // otherwise paths that skip an assignment infer a latch.
        grant_valid_o = 1'b0;
        idx_sum       = '0;
        for (int i = N - 1; i >= 0; i--) begin
            if (req_rot[i]) begin
                grant_valid_o = 1'b1;
                idx_sum       = {1'b0, ptr_q} + (SW+1)'(i);
            end
        end
        if (idx_sum >= (SW+1)'(N)) begin
            idx_sum = idx_sum - (SW+1)'(N);
        end
        grant_idx_o = idx_sum[SW-1:0];
    end

    // The next search starts one past the channel just granted, wrapping at N-1.
    always_comb begin
        ptr_d = ptr_q;
        if (advance_i) begin
            ptr_d = (grant_idx_o == SW'(N - 1)) ? '0 : grant_idx_o + 1'b1;
        end
    end

    // Pointer register.
    always_ff @(posedge clk or negedge rst_n) begin
        // NOTE: state registers use non-blocking assignments so every flop
        // samples the pre-edge values, whatever order the blocks are evaluated in.
        if (!rst_n) begin
            ptr_q <= '0;
        end else begin
            ptr_q <= ptr_d;
        end
    end

endmodule

// File: rtl/muxn_stream.sv
// N-channel, W-bit stream multiplexer. The chosen channel comes from sel
// (MODE_SEL) or from round-robin arbitration (MODE_RR). The chosen word goes
// into a single-entry output register with a valid/ready handshake. The
// register can take a new word on the same edge its old word drains, so the
// multiplexer sustains one word per cycle.
module muxn_stream
    import muxn_pkg::*;
#(
    parameter int N    = 4,
    parameter int W    = 8,
    parameter int MODE = MODE_SEL,
    parameter int SW   = $clog2(N)
) (
    input  logic           clk,
    input  logic           rst_n,
    input  logic [N*W-1:0] in_data,
    input  logic [N-1:0]   in_valid,
    output logic [N-1:0]   in_ready,
    input  logic [SW-1:0]  sel,
    output logic [W-1:0]   out_data,
    output logic           out_valid,
    input  logic           out_ready,
    output logic [SW-1:0]  out_grant
);

    logic             out_valid_q, out_valid_d;
    logic [W-1:0]     out_data_q, out_data_d;
    logic [SW-1:0]    out_grant_q, out_grant_d;

    logic             can_load;
    logic             load;
    logic             chosen_valid;
    logic [SW-1:0]    chosen_idx;
    logic [BUS_W-1:0] data_ext;
    logic [W-1:0]     words [N];
    logic [W-1:0]     load_word;

    // The register can accept a word when it is empty or draining this cycle.
    // rst_n gates it so that no channel sees ready while reset is held.
    assign can_load = rst_n && (!out_valid_q || out_ready);
    assign load     = can_load && chosen_valid;

    assign data_ext = BUS_W'(in_data);

    for (genvar g = 0; g < N; g++) begin : g_words
        assign words[g] = W'(channel_slice(data_ext, g, W));
    end

    if (MODE == MODE_RR) begin : g_rr
        logic unused_sel;
        assign unused_sel = ^sel;

        rr_arbiter #(
            .N  (N),
            .SW (SW)
        ) u_arb (
            .clk           (clk),
            .rst_n         (rst_n),
            .req_i         (in_valid),
            .advance_i     (load),
            .grant_valid_o (chosen_valid),
            .grant_idx_o   (chosen_idx)
        );
    end else begin : g_sel
        // Direct select decode. A sel value of N or more matches no channel.
        always_comb begin
            chosen_valid = 1'b0;
            chosen_idx   = sel;
            for (int i = 0; i < N; i++) begin
                if (sel == SW'(i) && in_valid[i]) begin
                    chosen_valid = 1'b1;
                end
            end
        end
    end

    assign in_ready = load ? (N'(1) << chosen_idx) : '0;

    // AND-OR mux on the one-hot ready vector selects the word being loaded.
    always_comb begin
        load_word = '0;
        for (int i = 0; i < N; i++) begin
            if (in_ready[i]) begin
                load_word = load_word | words[i];
            end
        end
    end

    // Next-state for the output stage: load replaces the word, drain-only empties it.
    always_comb begin
        out_valid_d = out_valid_q;
        out_data_d  = out_data_q;
        out_grant_d = out_grant_q;
        if (load) begin
            out_valid_d = 1'b1;
            out_data_d  = load_word;
            out_grant_d = chosen_idx;
        end else if (out_valid_q && out_ready) begin
            out_valid_d = 1'b0;
        end
    end

    // Output register stage.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            out_valid_q <= 1'b0;
            out_data_q  <= '0;
            out_grant_q <= '0;
        end else begin
            out_valid_q <= out_valid_d;
            out_data_q  <= out_data_d;
            out_grant_q <= out_grant_d;
        end
    end

    assign out_valid = out_valid_q;
    assign out_data  = out_data_q;
    assign out_grant = out_grant_q;

endmodule

// File: tb/tb_muxn_stream.sv
// Bench for muxn_stream. Three instances share one stimulus:
//   a: N=4 external select, b: N=4 round-robin, c: N=3 external select.
// A behavioural model of each instance is checked on every falling edge, and
// directed literal checks pin the model to known sequences.
module tb_muxn_stream;

    logic        clk = 1'b0;
    logic        rst_n;
    logic [31:0] in_data;
    logic [3:0]  in_valid;
    logic [1:0]  sel;
    logic        out_ready;

    logic [3:0] a_ready;  logic [7:0] a_data;  logic a_valid;  logic [1:0] a_grant;
    logic [3:0] b_ready;  logic [7:0] b_data;  logic b_valid;  logic [1:0] b_grant;
    logic [2:0] c_ready;  logic [7:0] c_data;  logic c_valid;  logic [1:0] c_grant;

    int checks = 0;
    int errors = 0;
    bit check_en = 1'b0;

    always #5 clk = ~clk;

    muxn_stream #(.N(4), .W(8), .MODE(0)) dut_a (
        .clk(clk), .rst_n(rst_n), .in_data(in_data), .in_valid(in_valid),
        .in_ready(a_ready), .sel(sel), .out_data(a_data), .out_valid(a_valid),
        .out_ready(out_ready), .out_grant(a_grant));

    muxn_stream #(.N(4), .W(8), .MODE(1)) dut_b (
        .clk(clk), .rst_n(rst_n), .in_data(in_data), .in_valid(in_valid),
        .in_ready(b_ready), .sel(sel), .out_data(b_data), .out_valid(b_valid),
        .out_ready(out_ready), .out_grant(b_grant));

    muxn_stream #(.N(3), .W(8), .MODE(0)) dut_c (
        .clk(clk), .rst_n(rst_n), .in_data(in_data[23:0]), .in_valid(in_valid[2:0]),
        .in_ready(c_ready), .sel(sel), .out_data(c_data), .out_valid(c_valid),
        .out_ready(out_ready), .out_grant(c_grant));

    // ---------------- behavioural model ----------------
    typedef struct {
        bit       valid;
        bit [7:0] data;
        int       grant;
        int       ptr;
    } mstate_t;

    mstate_t ma, mb, mc;

    function automatic mstate_t m_reset();
        mstate_t m;
        m.valid = 1'b0; m.data = 8'h00; m.grant = 0; m.ptr = 0;
        return m;
    endfunction

    // Channel the rules select this cycle, or -1 for none.
    function automatic int pick(int mode, int n, int ptr, bit [3:0] v, int s);
        if (mode == 0) begin
            if (s < n && v[s]) return s;
            return -1;
        end
        for (int k = 0; k < n; k++) begin
            if (v[(ptr + k) % n]) return (ptr + k) % n;
        end
        return -1;
    endfunction

    function automatic bit [3:0] exp_ready(int mode, int n, mstate_t m, bit rst,
                                           bit [3:0] v, int s, bit ordy);
        int ch;
        ch = pick(mode, n, m.ptr, v, s);
        if (!rst || (m.valid && !ordy) || ch < 0) return 4'b0000;
        return 4'b0001 << ch;
    endfunction

    function automatic mstate_t step(int mode, int n, mstate_t m, bit [31:0] d,
                                     bit [3:0] v, int s, bit ordy);
        mstate_t nx;
        int ch;
        nx = m;
        ch = pick(mode, n, m.ptr, v, s);
        if (ch >= 0 && (!m.valid || ordy)) begin
            nx.valid = 1'b1;
            nx.data  = d[ch*8 +: 8];
            nx.grant = ch;
            if (mode == 1) nx.ptr = (ch + 1) % n;
        end else if (m.valid && ordy) begin
            nx.valid = 1'b0;
        end
        return nx;
    endfunction

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ma = m_reset(); mb = m_reset(); mc = m_reset();
        end else begin
            ma = step(0, 4, ma, in_data, in_valid, int'(sel), out_ready);
            mb = step(1, 4, mb, in_data, in_valid, int'(sel), out_ready);
            mc = step(0, 3, mc, in_data, in_valid & 4'b0111, int'(sel), out_ready);
        end
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // Per-cycle comparison against the model, away from the rising edge.
    always @(negedge clk) begin
        if (check_en) begin
            check("m_a_ready", a_ready, exp_ready(0, 4, ma, rst_n, in_valid, int'(sel), out_ready));
            check("m_a_valid", a_valid, ma.valid);
            check("m_a_data",  a_data,  ma.data);
            check("m_a_grant", a_grant, ma.grant);
            check("m_b_ready", b_ready, exp_ready(1, 4, mb, rst_n, in_valid, int'(sel), out_ready));
            check("m_b_valid", b_valid, mb.valid);
            check("m_b_data",  b_data,  mb.data);
            check("m_b_grant", b_grant, mb.grant);
            check("m_c_ready", c_ready,
                  exp_ready(0, 3, mc, rst_n, in_valid & 4'b0111, int'(sel), out_ready));
            check("m_c_valid", c_valid, mc.valid);
            check("m_c_data",  c_data,  mc.data);
            check("m_c_grant", c_grant, mc.grant);
        end
    end

    // ---------------- directed stimulus ----------------
    task automatic cyc(input int k = 1);
        repeat (k) @(posedge clk);
        #1;
    endtask

    task automatic reset_dut();
        rst_n = 1'b0;
        in_valid = 4'b0000;
        cyc();
        rst_n = 1'b1;
    endtask

    int rr_seq [6] = '{0, 1, 2, 3, 0, 1};
    logic [7:0] ch_val [4] = '{8'h11, 8'h22, 8'hA5, 8'h44};

    initial begin
        rst_n = 1'b0; in_data = 32'h0; in_valid = 4'b0; sel = 2'd0; out_ready = 1'b0;
        #1 check_en = 1'b1;
        #2;
        // In reset: no ready even with every channel valid.
        in_valid = 4'b1111; out_ready = 1'b1;
        #1;
        check("rst_a_ready", a_ready, 4'b0000);
        check("rst_b_ready", b_ready, 4'b0000);
        check("rst_a_valid", a_valid, 1'b0);
        check("rst_a_data",  a_data,  8'h00);
        cyc(2);
        rst_n = 1'b1;
        in_valid = 4'b0000;
        in_data = 32'h44A5_2211;
        cyc();

        // Select channel 2.
        sel = 2'd2; in_valid = 4'b0100; out_ready = 1'b1;
        #1 check("sel2_ready", a_ready, 4'b0100);
        cyc();
        check("sel2_data",  a_data,  8'hA5);
        check("sel2_valid", a_valid, 1'b1);
        check("sel2_grant", a_grant, 2'd2);

        // Back-pressure with channel 1 waiting.
        sel = 2'd1; in_valid = 4'b0010; out_ready = 1'b0;
        #1 check("stall_ready", a_ready, 4'b0000);
        for (int i = 0; i < 5; i++) begin
            cyc();
            check("stall_data",  a_data,  8'hA5);
            check("stall_valid", a_valid, 1'b1);
        end
        out_ready = 1'b1;
        #1 check("drain_ready", a_ready, 4'b0010);
        cyc();
        check("swap_data",  a_data,  8'h22);
        check("swap_grant", a_grant, 2'd1);
        check("swap_valid", a_valid, 1'b1);
        in_valid = 4'b0000;
        cyc(2);

        // Round-robin, all valid, full throughput.
        reset_dut();
        sel = 2'd0; in_valid = 4'b1111; out_ready = 1'b1;
        for (int i = 0; i < 6; i++) begin
            cyc();
            check("rr_grant", b_grant, rr_seq[i]);
            check("rr_data",  b_data,  ch_val[rr_seq[i]]);
            check("rr_valid", b_valid, 1'b1);
        end

        // Wrap and skip from ptr=3.
        reset_dut();
        in_valid = 4'b0100;
        cyc();
        check("ws_first", b_grant, 2'd2);
        in_valid = 4'b0011;
        cyc();
        check("ws_wrap", b_grant, 2'd0);
        cyc();
        check("ws_skip", b_grant, 2'd1);
        in_valid = 4'b1111;
        cyc();
        check("ws_ptr2", b_grant, 2'd2);

        // N=3 with out-of-range select.
        reset_dut();
        sel = 2'd3; in_valid = 4'b0111; out_ready = 1'b1;
        #1 check("oor_ready", c_ready, 3'b000);
        cyc(3);
        check("oor_valid", c_valid, 1'b0);
        sel = 2'd1;
        cyc();
        check("c_sel1_grant", c_grant, 2'd1);
        check("c_sel1_data",  c_data,  8'h22);

        // Reset during a stall.
        in_valid = 4'b1111; out_ready = 1'b1;
        cyc();
        out_ready = 1'b0;
        cyc();
        check("pre_rst_valid", b_valid, 1'b1);
        #2 rst_n = 1'b0;
        #1;
        check("async_b_valid", b_valid, 1'b0);
        check("async_a_valid", a_valid, 1'b0);
        @(posedge clk);
        #1 rst_n = 1'b1;
        out_ready = 1'b1; in_valid = 4'b1111;
        cyc();
        check("post_rst_grant", b_grant, 2'd0);
        check("post_rst_valid", b_valid, 1'b1);

        in_valid = 4'b0000;
        cyc(2);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/muxn_stream.md
# muxn_stream

Parametrised N-channel, W-bit stream multiplexer, the registered successor to the single-bit 2:1 mux. It selects one of N valid/ready input channels, either by an external select or by round-robin arbitration, and registers the chosen word into a single-entry output stage with a valid/ready handshake. It sits between multiple producer streams and one shared consumer.

## Interface
- N, default 4: number of input channels, 2..16.
- W, default 8: data width per channel, 1..64.
- MODE, default 0: 0 = external select (sel port), 1 = round-robin arbitration (sel ignored).
- SW, default $clog2(N): select/grant width, derived, not overridden.
- clk  in  1  single clock; all state on rising edge.
- rst_n  in  1  asynchronous, active-low reset; asserts immediately, releases synchronously to clk.
- in_data  in  N*W  channel i occupies bits [i*W +: W].
- in_valid  in  N  per-channel valid.
- in_ready  out  N  per-channel ready; at most one bit high.
- sel  in  SW  channel select, MODE 0 only.
- out_data  out  W  registered output word.
- out_valid  out  1  output word valid.
- out_ready  in  1  consumer ready.
- out_grant  out  SW  index of channel that supplied out_data.

## Operation
- can_load = !out_valid || out_ready (output register empty or draining this cycle).
- Chosen channel:
  - MODE 0: chosen = sel when sel < N and in_valid[sel]. Otherwise none.
  - MODE 1: chosen = first i with in_valid[i], searching ptr, ptr+1, ... N-1, 0, ... ptr-1 (mod N). None if no valid.
- in_ready[i] = can_load && (i == chosen); combinational, depends on out_ready and out_valid only through can_load.
- Input transfer on in_valid[i] && in_ready[i]:
  - out_data <= word i.
  - out_grant <= i.
  - out_valid <= 1.
  - MODE 1 only: ptr <= (i == N-1) ? 0 : i+1.
- Output transfer on out_valid && out_ready with no input transfer: out_valid <= 0. out_data and out_grant hold their last values.
- Simultaneous output and input transfer: the new word replaces the old one in the same edge; out_valid stays 1. This gives full throughput of 1 word/cycle.
- Stall (out_valid && !out_ready): out_data and out_grant are stable, all in_ready are 0, and ptr holds.
- sel may change any cycle; it is sampled only in the cycle of a transfer. sel >= N (non-power-of-two N) selects no channel, and all in_ready are 0.
- MODE 1 fairness: a continuously valid channel is granted within N transfers.

## Timing
- Reset values: out_valid=0, out_data=0, out_grant=0, ptr=0. in_ready is all-zero while rst_n is low.
- Latency: input transfer at edge k → out_valid=1 with that data after edge k, visible in cycle k+1.
- in_ready has a combinational path from out_ready, sel and in_valid; there is no combinational path from in_data to any output.
- Reset mid-operation: a held output word is discarded; ptr returns to 0. The first cycle after release behaves as empty.

## Structure
- Package muxn_pkg holds:
  - MODE_SEL=0 and MODE_RR=1 constants.
  - A helper function for channel-slice extraction.
- Sub-module rr_arbiter(N): combinational priority search from ptr, plus the ptr register with an update enable. Instantiated only when MODE=1; MODE 0 uses a direct sel decode.

## Test plan
- Reset, then MODE 0 (N=4, W=8), sel=2, in_valid=4'b0100, in_data[2]=8'hA5, out_ready=1 → in_ready=4'b0100; next cycle out_data=A5, out_valid=1, out_grant=2.
- Back-pressure: out_ready=0 with a word held, new valid on channel 1 → in_ready=0000; out_data is unchanged for 5 cycles. Raising out_ready accepts channel 1 on the same edge the old word drains.
- MODE 1, all four channels valid every cycle, out_ready=1 → out_grant sequence 0,1,2,3,0,1 with one word per cycle.
- MODE 1 wrap and skip: ptr=3, in_valid=4'b0011 → channel 0 granted, then channel 1. ptr ends at 2.
- N=3 in MODE 0, sel=3 with all valid → in_ready=000 and out_valid stays 0.
- Assert rst_n low while out_valid=1 mid-stall → out_valid drops immediately without waiting for a clock. After release, round-robin restarts at channel 0.
